// File: rtl/maze_cmd_sequencer.sv
// Route sequencer for the MazeRunner: accepts UART commands, walks a 3-slot turn list at
// line gaps, steers open-loop through the gap, and handles route end and bump events.
module maze_cmd_sequencer #(
  parameter bit          FAST_SIM = 1'b1,
  parameter logic [15:0] VEER_ERR = 16'h0340,
  parameter logic [21:0] VEER_CYC = 22'd3_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic        line_present,
  input  logic        BMPL_n,
  input  logic        BMPR_n,
  output logic        go,
  output logic [15:0] err_opn_lp,
  output logic        buzz,
  output logic        send_resp
);

  typedef enum logic [2:0] {IDLE, MOVE, VEER, STOP, BUMPED} state_t;

  localparam logic [1:0]  T_END   = 2'b00;
  localparam logic [1:0]  T_RIGHT = 2'b01;
  localparam logic [1:0]  T_LEFT  = 2'b10;
  localparam logic [21:0] VEER_TERM = FAST_SIM ? 22'd1024 : VEER_CYC;

  state_t      state_q, state_d;
  logic [5:0]  turns_q, turns_d;
  logic [1:0]  dir_q, dir_d;
  logic [21:0] timer_q, timer_d;
  logic [14:0] bz_cnt_q, bz_cnt_d;
  logic        bmpl_s1_q, bmpl_s2_q, bmpr_s1_q, bmpr_s2_q;
  logic        bmpl_s1_d, bmpl_s2_d, bmpr_s1_d, bmpr_s2_d;
  logic        line_prev_q, line_prev_d;
  logic        cmd_rdy_prev_q, cmd_rdy_prev_d;
  logic        go_q, go_d, buzz_q, buzz_d, resp_q, resp_d, clr_q, clr_d;
  logic [15:0] err_q, err_d;
  logic        accept, is_stop, is_go, gap, bmp;

  always_comb begin
    bmpl_s1_d      = BMPL_n;
    bmpl_s2_d      = bmpl_s1_q;
    bmpr_s1_d      = BMPR_n;
    bmpr_s2_d      = bmpr_s1_q;
    line_prev_d    = line_present;
    cmd_rdy_prev_d = cmd_rdy;

    // One acceptance per cmd_rdy assertion, however long the receiver holds it.
    accept  = cmd_rdy & ~cmd_rdy_prev_q;
    is_stop = accept & (cmd[7:6] == 2'b00);
    is_go   = accept & (cmd[7:6] == 2'b01);
    gap     = line_prev_q & ~line_present;
    bmp     = ~bmpl_s2_q | ~bmpr_s2_q;

    state_d  = state_q;
    turns_d  = turns_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    bz_cnt_d = '0;

    if (bmp && go_q) begin
      state_d = BUMPED;
    end else if (is_stop) begin
      state_d = IDLE;
      turns_d = '0;
    end else if (is_go) begin
      state_d = MOVE;
      turns_d = cmd[5:0];
      timer_d = '0;
    end else begin
      case (state_q)
        MOVE: if (gap) begin
          turns_d = {2'b00, turns_q[5:2]};
          if (turns_q[1:0] == T_END) begin
            state_d = STOP;
          end else begin
            state_d = VEER;
            dir_d   = turns_q[1:0];
            timer_d = '0;
          end
        end
        VEER: begin
          // Saturate so a long-lost line cannot wrap the timer below terminal.
          if (timer_q < VEER_TERM) timer_d = timer_q + 22'd1;
          if ((timer_q >= VEER_TERM) && line_present) state_d = MOVE;
        end
        STOP:    state_d = IDLE;
        default: ;
      endcase
    end

    if ((state_d == BUMPED) && (state_q == BUMPED)) bz_cnt_d = bz_cnt_q + 15'd1;

    go_d   = (state_d == MOVE) || (state_d == VEER);
    err_d  = '0;
    if (state_d == VEER) begin
      if (dir_d == T_RIGHT)     err_d = VEER_ERR;
      else if (dir_d == T_LEFT) err_d = ~VEER_ERR + 16'd1;
    end
    buzz_d = (state_d == BUMPED) ? (FAST_SIM ? bz_cnt_d[4] : bz_cnt_d[14]) : 1'b0;
    resp_d = (state_d == STOP) && (state_q != STOP);
    clr_d  = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      turns_q        <= '0;
      dir_q          <= T_END;
      timer_q        <= '0;
      bz_cnt_q       <= '0;
      bmpl_s1_q      <= 1'b1;
      bmpl_s2_q      <= 1'b1;
      bmpr_s1_q      <= 1'b1;
      bmpr_s2_q      <= 1'b1;
      line_prev_q    <= 1'b0;
      cmd_rdy_prev_q <= 1'b0;
      go_q           <= 1'b0;
      err_q          <= '0;
      buzz_q         <= 1'b0;
      resp_q         <= 1'b0;
      clr_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      turns_q        <= turns_d;
      dir_q          <= dir_d;
      timer_q        <= timer_d;
      bz_cnt_q       <= bz_cnt_d;
      bmpl_s1_q      <= bmpl_s1_d;
      bmpl_s2_q      <= bmpl_s2_d;
      bmpr_s1_q      <= bmpr_s1_d;
      bmpr_s2_q      <= bmpr_s2_d;
      line_prev_q    <= line_prev_d;
      cmd_rdy_prev_q <= cmd_rdy_prev_d;
      go_q           <= go_d;
      err_q          <= err_d;
      buzz_q         <= buzz_d;
      resp_q         <= resp_d;
      clr_q          <= clr_d;
    end
  end

  assign go          = go_q;
  assign err_opn_lp  = err_q;
  assign buzz        = buzz_q;
  assign send_resp   = resp_q;
  assign clr_cmd_rdy = clr_q;

endmodule
